// File: rtl/spi_host_byte_pipe.sv
// spi_host_byte_pipe
//   Sits between the SPI host data FIFOs and the shift engine.
//   TX: takes 36-bit {data, byte-enable} words and serializes the enabled
//       bytes one at a time. Disabled bytes are skipped. An all-zero enable
//       word is accepted and dropped.
//   RX: packs received bytes into 32-bit words. A word is pushed when four
//       bytes have arrived or when a byte is marked last. Lanes that were not
//       filled read as zero.
//
// Parameters
//   ByteOrder : 0 = byte lane 0 (bits [7:0]) first, 1 = byte lane 3 first.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   word_data_i/be_i        TX word and byte enables from the TX FIFO
//   word_valid_i/ready_o    TX word handshake
//   tx_byte_o/valid_o       byte to the shift engine
//   tx_byte_ready_i         shift engine takes the byte
//   rx_byte_i/last_i        byte from the shift engine, end-of-segment flag
//   rx_byte_valid_i/ready_o RX byte handshake
//   word_data_o/valid_o     packed RX word to the RX FIFO
//   word_ready_i            RX FIFO accepts the word
//   flush_i                 synchronous clear of all state
//   tx_idle_o, rx_idle_o    no TX bytes pending / RX packer and output empty
//
// Optional build macro SPI_HOST_BYTE_PIPE_STATS_EN adds tx_byte_cnt_o and
// rx_byte_cnt_o, saturating 16-bit byte handshake counters.

module spi_host_byte_pipe #(
  parameter logic ByteOrder = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] word_data_i,
  input  logic [3:0]  word_be_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic [7:0]  tx_byte_o,
  output logic        tx_byte_valid_o,
  input  logic        tx_byte_ready_i,
  input  logic [7:0]  rx_byte_i,
  input  logic        rx_byte_last_i,
  input  logic        rx_byte_valid_i,
  output logic        rx_byte_ready_o,
  output logic [31:0] word_data_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  input  logic        flush_i,
  output logic        tx_idle_o,
  output logic        rx_idle_o
`ifdef SPI_HOST_BYTE_PIPE_STATS_EN
  ,
  output logic [15:0] tx_byte_cnt_o,
  output logic [15:0] rx_byte_cnt_o
`endif
);

  // ---------------------------------------------------------------- TX side
  logic [31:0] tx_data;
  logic [3:0]  tx_mask;
  logic [3:0]  tx_sel;
  logic [1:0]  tx_lane;
  logic [7:0]  tx_byte;
  logic        tx_single;
  logic        tx_fire;
  logic        word_fire;

  // Pick the first pending lane in transmit order.
  always_comb begin
    tx_sel  = '0;
    tx_byte = '0;
    tx_lane = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      tx_lane = ByteOrder ? 2'(3 - i) : 2'(i);
      if (tx_mask[tx_lane] && (tx_sel == '0)) begin
        tx_sel[tx_lane] = 1'b1;
        tx_byte         = tx_data[{tx_lane, 3'b000} +: 8];
      end
    end
  end

  assign tx_single       = (tx_mask != '0) && ((tx_mask & (tx_mask - 4'd1)) == '0);
  assign tx_byte_valid_o = |tx_mask;
  assign tx_byte_o       = tx_byte;
  assign tx_fire         = tx_byte_valid_o & tx_byte_ready_i;
  // Accept the next word while the last pending byte is leaving, so words
  // stream back to back without a bubble.
  assign word_ready_o    = (tx_mask == '0) | (tx_single & tx_byte_ready_i);
  assign word_fire       = word_valid_i & word_ready_o;
  assign tx_idle_o       = (tx_mask == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_data <= '0;
      tx_mask <= '0;
    end else if (flush_i) begin
      tx_data <= '0;
      tx_mask <= '0;
    end else if (word_fire) begin
      // A word can only land when the final byte (if any) leaves this cycle,
      // so replacing the mask outright is correct.
      tx_data <= word_data_i;
      tx_mask <= word_be_i;
    end else if (tx_fire) begin
      tx_mask <= tx_mask & ~tx_sel;
    end
  end

  // ---------------------------------------------------------------- RX side
  logic [31:0] rx_asm;
  logic [31:0] rx_asm_next;
  logic [2:0]  rx_count;
  logic [1:0]  rx_lane;
  logic        rx_fire;
  logic        rx_done;
  logic        out_pop;

  assign rx_byte_ready_o = !word_valid_o | word_ready_i;
  assign rx_fire         = rx_byte_valid_i & rx_byte_ready_o;
  assign rx_lane         = ByteOrder ? 2'(3'd3 - rx_count) : rx_count[1:0];
  assign rx_done         = rx_fire & ((rx_count == 3'd3) | rx_byte_last_i);
  assign out_pop         = word_valid_o & word_ready_i;
  assign rx_idle_o       = (rx_count == '0) & !word_valid_o;

  // The assembly register is cleared whenever a word completes, so lanes not
  // yet written are already zero when a short word is pushed out.
  always_comb begin
    rx_asm_next = rx_asm;
    for (int unsigned i = 0; i < 4; i++) begin
      if (rx_lane == 2'(i)) begin
        rx_asm_next[8*i +: 8] = rx_byte_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_asm       <= '0;
      rx_count     <= '0;
      word_data_o  <= '0;
      word_valid_o <= 1'b0;
    end else if (flush_i) begin
      rx_asm       <= '0;
      rx_count     <= '0;
      word_data_o  <= '0;
      word_valid_o <= 1'b0;
    end else if (rx_done) begin
      // Output register is free or being popped this cycle; overwrite it.
      word_data_o  <= rx_asm_next;
      word_valid_o <= 1'b1;
      rx_asm       <= '0;
      rx_count     <= '0;
    end else begin
      if (rx_fire) begin
        rx_asm   <= rx_asm_next;
        rx_count <= rx_count + 3'd1;
      end
      if (out_pop) begin
        word_valid_o <= 1'b0;
      end
    end
  end

`ifdef SPI_HOST_BYTE_PIPE_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_byte_cnt_o <= '0;
      rx_byte_cnt_o <= '0;
    end else if (flush_i) begin
      tx_byte_cnt_o <= '0;
      rx_byte_cnt_o <= '0;
    end else begin
      if (tx_fire && (tx_byte_cnt_o != '1)) begin
        tx_byte_cnt_o <= tx_byte_cnt_o + 16'd1;
      end
      if (rx_fire && (rx_byte_cnt_o != '1)) begin
        rx_byte_cnt_o <= rx_byte_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule
